// File: rtl/axil_dma_seq.sv
// Single-channel DMA copy sequencer: one AXI-Lite read then one AXI-Lite write per beat,
// with a single beat in flight at a time. Abort and write errors end the transfer once the current beat finishes.
module axil_dma_seq #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  anreset,
    input  logic                  aenable,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_aborted,
    output logic [LEN_WIDTH-1:0]  o_beats,
    output logic                  o_rd_req,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic                  i_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_wr_req,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [STRB_WIDTH-1:0] o_wr_strb,
    input  logic                  i_wr_done,
    input  logic                  i_wr_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  aborted_q, aborted_d;
    logic                  abort_flag_q, abort_flag_d;
    logic                  abort_pend;

    // An abort arriving in the same cycle as the write response still counts for this beat.
    assign abort_pend = abort_flag_q | i_abort;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        beats_d      = beats_q;
        data_d       = data_q;
        err_d        = err_q;
        aborted_d    = aborted_q;
        abort_flag_d = abort_flag_q;

        if (state_q != S_IDLE && i_abort) begin
            abort_flag_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    src_d        = i_src_addr;
                    dst_d        = i_dst_addr;
                    rem_d        = i_len;
                    beats_d      = '0;
                    err_d        = 1'b0;
                    aborted_d    = 1'b0;
                    abort_flag_d = 1'b0;
                    state_d      = (i_len == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (i_rd_valid) begin
                    data_d  = i_rd_data;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (i_wr_done) begin
                    beats_d = beats_q + LEN_WIDTH'(1);
                    if (i_wr_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (abort_pend) begin
                        aborted_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        src_d   = src_q + ADDR_WIDTH'(STRB_WIDTH);
                        dst_d   = dst_q + ADDR_WIDTH'(STRB_WIDTH);
                        rem_d   = rem_q - LEN_WIDTH'(1);
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge anreset) begin
        if (!anreset) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            beats_q      <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            aborted_q    <= 1'b0;
            abort_flag_q <= 1'b0;
        end else if (aenable) begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            beats_q      <= beats_d;
            data_q       <= data_d;
            err_q        <= err_d;
            aborted_q    <= aborted_d;
            abort_flag_q <= abort_flag_d;
        end
    end

    // Pulses are gated by aenable so a stalled request state is never seen as a second request.
    assign o_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done    = (state_q == S_DONE) && aenable;
    assign o_rd_req  = (state_q == S_RD_REQ) && aenable;
    assign o_wr_req  = (state_q == S_WR_REQ) && aenable;
    assign o_err     = err_q;
    assign o_aborted = aborted_q;
    assign o_beats   = beats_q;
    assign o_rd_addr = src_q;
    assign o_wr_addr = dst_q;
    assign o_wr_data = data_q;
    assign o_wr_strb = '1;

endmodule

// File: tb/tb_axil_dma_seq.sv
// Directed bench for axil_dma_seq: fixed-latency rd/wr engine models plus a linear test sequence.
module tb_axil_dma_seq;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int LW = 16;

    logic          aclk = 1'b0;
    logic          anreset = 1'b0;
    logic          aenable = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [AW-1:0] i_src_addr = '0;
    logic [AW-1:0] i_dst_addr = '0;
    logic [LW-1:0] i_len = '0;
    logic          i_rd_valid = 1'b0;
    logic [DW-1:0] i_rd_data = '0;
    logic          i_wr_done = 1'b0;
    logic          i_wr_err = 1'b0;
    logic          o_busy, o_done, o_err, o_aborted, o_rd_req, o_wr_req;
    logic [LW-1:0] o_beats;
    logic [AW-1:0] o_rd_addr, o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic [SW-1:0] o_wr_strb;

    axil_dma_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .LEN_WIDTH(LW)) dut (
        .aclk(aclk), .anreset(anreset), .aenable(aenable),
        .i_start(i_start), .i_abort(i_abort),
        .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_aborted(o_aborted), .o_beats(o_beats),
        .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
        .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_strb(o_wr_strb),
        .i_wr_done(i_wr_done), .i_wr_err(i_wr_err)
    );

    always #5 aclk = ~aclk;

    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    int            rd_lat = 2;
    int            wr_lat = 2;
    int            err_beat = 0;
    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] wr_log[$];
    logic [DW-1:0] wd_log[$];
    logic [AW-1:0] ra;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return 64'hC0DE_0000_0000_0000 | {48'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read engine: data returned rd_lat enabled cycles after the request.
    initial begin
        forever begin
            @(negedge aclk);
            if (o_rd_req && anreset) begin
                rd_log.push_back(o_rd_addr);
                ra = o_rd_addr;
                repeat (rd_lat) begin
                    forever begin @(posedge aclk); if (aenable) break; end
                end
                @(negedge aclk);
                i_rd_valid = 1'b1;
                i_rd_data  = mem(ra);
                forever begin @(posedge aclk); if (aenable) break; end
                @(negedge aclk);
                i_rd_valid = 1'b0;
            end
        end
    end

    // Write engine: response wr_lat enabled cycles after the request; error on write number err_beat.
    initial begin
        forever begin
            @(negedge aclk);
            if (o_wr_req && anreset) begin
                wr_log.push_back(o_wr_addr);
                wd_log.push_back(o_wr_data);
                repeat (wr_lat) begin
                    forever begin @(posedge aclk); if (aenable) break; end
                end
                @(negedge aclk);
                i_wr_done = 1'b1;
                i_wr_err  = (wr_log.size() == err_beat);
                forever begin @(posedge aclk); if (aenable) break; end
                @(negedge aclk);
                i_wr_done = 1'b0;
                i_wr_err  = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            if (o_done) done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
        rd_log.delete();
        wr_log.delete();
        wd_log.delete();
        done_cnt = 0;
        @(negedge aclk);
        i_src_addr = s;
        i_dst_addr = d;
        i_len      = l;
        i_start    = 1'b1;
        @(negedge aclk);
        i_start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge aclk);
            seen = o_done;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_cnt(input bit wr, input int n, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge aclk);
            #1;
            ok = ((wr ? wr_log.size() : rd_log.size()) >= n);
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_ctl", 64'({o_busy, o_done, o_err, o_aborted, o_rd_req, o_wr_req}), 64'd0);
        chk("rst_beats", 64'(o_beats), 64'd0);
        chk("rst_addr", 64'({o_rd_addr, o_wr_addr}), 64'd0);
        chk("rst_data", o_wr_data, 64'd0);
        chk("rst_strb", 64'(o_wr_strb), 64'hFF);
        anreset = 1'b1;

        // Plain 3-word copy
        start_xfer(16'h0100, 16'h0800, 16'd3);
        chk("t1_busy", 64'(o_busy), 64'd1);
        wait_done("t1_done_seen");
        chk("t1_busy_at_done", 64'(o_busy), 64'd0);
        @(negedge aclk);
        chk("t1_nrd", 64'(rd_log.size()), 64'd3);
        chk("t1_nwr", 64'(wr_log.size()), 64'd3);
        chk("t1_rd0", 64'(rd_log[0]), 64'h0100);
        chk("t1_rd1", 64'(rd_log[1]), 64'h0108);
        chk("t1_rd2", 64'(rd_log[2]), 64'h0110);
        chk("t1_wr0", 64'(wr_log[0]), 64'h0800);
        chk("t1_wr1", 64'(wr_log[1]), 64'h0808);
        chk("t1_wr2", 64'(wr_log[2]), 64'h0810);
        chk("t1_wd0", wd_log[0], mem(16'h0100));
        chk("t1_wd1", wd_log[1], mem(16'h0108));
        chk("t1_wd2", wd_log[2], mem(16'h0110));
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_beats", 64'(o_beats), 64'd3);
        chk("t1_flags", 64'({o_err, o_aborted, o_done}), 64'd0);

        // Zero length: straight to DONE without bus traffic
        start_xfer(16'h0100, 16'h0800, 16'd0);
        chk("t2_done", 64'(o_done), 64'd1);
        chk("t2_busy", 64'(o_busy), 64'd0);
        @(negedge aclk);
        chk("t2_done_off", 64'(o_done), 64'd0);
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);
        chk("t2_traffic", 64'(rd_log.size() + wr_log.size()), 64'd0);
        chk("t2_beats", 64'(o_beats), 64'd0);

        // Write error on beat 2, with an abort in the same beat: error wins
        err_beat = 2;
        start_xfer(16'h2000, 16'h3000, 16'd4);
        wait_cnt(1'b0, 2, "t3_rd2_seen");
        @(negedge aclk);
        i_abort = 1'b1;
        @(negedge aclk);
        i_abort = 1'b0;
        wait_done("t3_done_seen");
        @(negedge aclk);
        err_beat = 0;
        chk("t3_nwr", 64'(wr_log.size()), 64'd2);
        chk("t3_err", 64'(o_err), 64'd1);
        chk("t3_aborted", 64'(o_aborted), 64'd0);
        chk("t3_beats", 64'(o_beats), 64'd2);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);

        // Abort during beat 3 read wait: beat 3 still written
        start_xfer(16'h4000, 16'h5000, 16'd8);
        chk("t4_err_cleared", 64'(o_err), 64'd0);
        wait_cnt(1'b0, 3, "t4_rd3_seen");
        @(negedge aclk);
        i_abort = 1'b1;
        @(negedge aclk);
        i_abort = 1'b0;
        wait_done("t4_done_seen");
        @(negedge aclk);
        chk("t4_nwr", 64'(wr_log.size()), 64'd3);
        chk("t4_wr2", 64'(wr_log[2]), 64'h5010);
        chk("t4_wd2", wd_log[2], mem(16'h4010));
        chk("t4_aborted", 64'(o_aborted), 64'd1);
        chk("t4_err", 64'(o_err), 64'd0);
        chk("t4_beats", 64'(o_beats), 64'd3);

        // Address wrap plus a 5-cycle clock-enable stall with read data pending
        start_xfer(16'hFFF8, 16'h6000, 16'd2);
        chk("t5_aborted_cleared", 64'(o_aborted), 64'd0);
        wait_cnt(1'b0, 2, "t5_rd2_seen");
        @(negedge aclk);
        @(negedge aclk);
        aenable = 1'b0;
        repeat (5) @(negedge aclk);
        chk("t5_frz_ctl", 64'({o_busy, o_done, o_rd_req, o_wr_req}), 64'b1000);
        chk("t5_frz_beats", 64'(o_beats), 64'd1);
        chk("t5_frz_rd_addr", 64'(o_rd_addr), 64'h0000);
        chk("t5_frz_wr_addr", 64'(o_wr_addr), 64'h6008);
        chk("t5_frz_wr_data", o_wr_data, mem(16'hFFF8));
        aenable = 1'b1;
        wait_done("t5_done_seen");
        @(negedge aclk);
        chk("t5_rd1", 64'(rd_log[1]), 64'h0000);
        chk("t5_wr1", 64'(wr_log[1]), 64'h6008);
        chk("t5_wd0", wd_log[0], mem(16'hFFF8));
        chk("t5_wd1", wd_log[1], mem(16'h0000));
        chk("t5_beats", 64'(o_beats), 64'd2);
        chk("t5_done_cnt", 64'(done_cnt), 64'd1);

        // Reset in WR_WAIT, then a fresh transfer
        start_xfer(16'h0200, 16'h0A00, 16'd2);
        wait_cnt(1'b1, 1, "t6_wr1_seen");
        @(negedge aclk);
        anreset = 1'b0;
        #1;
        chk("t6_rst_ctl", 64'({o_busy, o_done, o_err, o_aborted, o_rd_req, o_wr_req}), 64'd0);
        chk("t6_rst_beats", 64'(o_beats), 64'd0);
        chk("t6_rst_addr", 64'({o_rd_addr, o_wr_addr}), 64'd0);
        chk("t6_rst_data", o_wr_data, 64'd0);
        chk("t6_rst_strb", 64'(o_wr_strb), 64'hFF);
        repeat (3) @(negedge aclk);
        anreset = 1'b1;
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        start_xfer(16'h0300, 16'h0B00, 16'd1);
        wait_done("t6_done_seen");
        @(negedge aclk);
        chk("t6_wr0", 64'(wr_log[0]), 64'h0B00);
        chk("t6_wd0", wd_log[0], mem(16'h0300));
        chk("t6_beats", 64'(o_beats), 64'd1);
        chk("t6_done_cnt", 64'(done_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
